// File: rtl/led_pattern_pkg.sv
// Shared types and start-value helper for the LED pattern generator.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_WALK   = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int MAX_WIDTH = 64;

  // Value shown on the first tick after switching into a mode; callers truncate to their width.
  function automatic logic [MAX_WIDTH-1:0] startValue(input mode_t m, input int width);
    logic [MAX_WIDTH-1:0] ones;
    ones = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
    case (m)
      MODE_DOWN: return ones;
      MODE_WALK: return 64'd1;
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_counter_counter.sv
// Modulo-N counter with clock enable; ov flags the terminal count while enabled.
module counter #(
  parameter int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  output logic [W-1:0] q,
  output logic         ov
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (ce) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q  = count_q;
  assign ov = ce && (count_q == LAST);

endmodule

// File: rtl/led_pattern_counter.sv
// LED pattern generator: prescaled tick advances an up/down/bounce/walking-one display.
module led_pattern_counter
  import led_pattern_pkg::*;
#(
  parameter int DIV   = 800000,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic             tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [PW-1:0]    prescaleUnused;
  logic             ov;

  logic [WIDTH-1:0] val_q, val_d;
  mode_t            actMode_q, actMode_d;
  dir_t             dir_q, dir_d;
  mode_t            reqMode;

  // ov is already qualified by ce, so it can drive tick directly.
  counter #(.N(DIV)) uPrescale (
    .clk (clk),
    .rst (rst),
    .ce  (en),
    .q   (prescaleUnused),
    .ov  (ov)
  );

  assign tick    = ov;
  assign reqMode = mode_t'(mode);

  always_comb begin
    val_d     = val_q;
    actMode_d = actMode_q;
    dir_d     = dir_q;
    if (tick) begin
      if (reqMode != actMode_q) begin
        actMode_d = reqMode;
        val_d     = WIDTH'(startValue(reqMode, WIDTH));
        dir_d     = DIR_UP;
      end else begin
        case (actMode_q)
          MODE_UP:   val_d = val_q + 1'b1;
          MODE_DOWN: val_d = val_q - 1'b1;
          MODE_BOUNCE: begin
            if (dir_q == DIR_UP) begin
              if (val_q == ALL_ONES) begin
                dir_d = DIR_DOWN;
                val_d = ALL_ONES - 1'b1;
              end else begin
                val_d = val_q + 1'b1;
              end
            end else begin
              if (val_q == '0) begin
                dir_d = DIR_UP;
                val_d = ONE;
              end else begin
                val_d = val_q - 1'b1;
              end
            end
          end
          default: begin
            // A corrupted walk pattern recovers by restarting from bit 0.
            if (!$onehot(val_q)) begin
              val_d = ONE;
              dir_d = DIR_UP;
            end else if (dir_q == DIR_UP) begin
              if (val_q[WIDTH-1]) begin
                dir_d = DIR_DOWN;
                val_d = val_q >> 1;
              end else begin
                val_d = val_q << 1;
              end
            end else begin
              if (val_q[0]) begin
                dir_d = DIR_UP;
                val_d = val_q << 1;
              end else begin
                val_d = val_q >> 1;
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q     <= '0;
      actMode_q <= MODE_UP;
      dir_q     <= DIR_UP;
    end else begin
      val_q     <= val_d;
      actMode_q <= actMode_d;
      dir_q     <= dir_d;
    end
  end

  assign led = val_q;

endmodule

// File: tb/tb_led_pattern_counter.sv
// Directed self-checking bench for led_pattern_counter with DIV=4 at widths 8, 3 and 4.
module tb_led_pattern_counter;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;

  logic [7:0] led8;
  logic [2:0] led3;
  logic [3:0] led4;
  logic       tick8, tick3, tick4;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  led_pattern_counter #(.DIV(DIV), .WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .led(led8), .tick(tick8));
  led_pattern_counter #(.DIV(DIV), .WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .led(led3), .tick(tick3));
  led_pattern_counter #(.DIV(DIV), .WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .led(led4), .tick(tick4));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic enV, input logic [1:0] modeV);
    en   = enV;
    mode = modeV;
    #1;
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic stepCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset(input logic [1:0] modeV);
    rst = 1'b1;
    applyStimulus(1'b1, modeV);
    stepCycles(2);
    rst = 1'b0;
    #1;
  endtask

  logic [2:0] bounceSeq [17] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                                 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
  logic [3:0] walkSeq [8] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd2};

  initial begin
    rst  = 1'b1;
    en   = 1'b1;
    mode = 2'd0;

    // UP from reset: release cycle is cycle 0
    doReset(2'd0);
    checkOutput("reset_led", 32'(led8), 32'h00);
    checkOutput("reset_tick", 32'(tick8), 32'h0);
    stepCycles(3);
    checkOutput("up_tick_c3", 32'(tick8), 32'h1);
    checkOutput("up_led_c3", 32'(led8), 32'h00);
    stepCycles(1);
    checkOutput("up_led_1", 32'(led8), 32'h01);
    checkOutput("up_tick_c4", 32'(tick8), 32'h0);
    stepCycles(3);
    checkOutput("up_tick_c7", 32'(tick8), 32'h1);
    stepCycles(1);
    checkOutput("up_led_2", 32'(led8), 32'h02);
    stepCycles(1012);
    checkOutput("up_led_ff", 32'(led8), 32'hFF);
    stepCycles(4);
    checkOutput("up_wrap", 32'(led8), 32'h00);

    // Mode glitch between ticks is ignored
    applyStimulus(1'b1, 2'd3);
    stepCycles(2);
    applyStimulus(1'b1, 2'd0);
    stepCycles(1);
    checkOutput("glitch_tick", 32'(tick8), 32'h1);
    stepCycles(1);
    checkOutput("glitch_led", 32'(led8), 32'h01);

    // en low for 10 cycles from prescaler=2
    stepCycles(2);
    applyStimulus(1'b0, 2'd0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("freeze_tick", 32'(tick8), 32'h0);
      checkOutput("freeze_led", 32'(led8), 32'h01);
      stepCycles(1);
    end
    applyStimulus(1'b1, 2'd0);
    checkOutput("resume_tick_c0", 32'(tick8), 32'h0);
    stepCycles(1);
    checkOutput("resume_tick_c1", 32'(tick8), 32'h1);
    stepCycles(1);
    checkOutput("resume_led", 32'(led8), 32'h02);

    // en dropped on a would-be tick holds the terminal count
    stepCycles(3);
    checkOutput("wb_tick_pre", 32'(tick8), 32'h1);
    applyStimulus(1'b0, 2'd0);
    checkOutput("wb_tick_supp", 32'(tick8), 32'h0);
    stepCycles(2);
    checkOutput("wb_led_hold", 32'(led8), 32'h02);
    applyStimulus(1'b1, 2'd0);
    checkOutput("wb_tick_fire", 32'(tick8), 32'h1);
    stepCycles(1);
    checkOutput("wb_led", 32'(led8), 32'h03);

    // Reset pulse mid-period with a pending mode change, then DOWN
    stepCycles(1);
    rst = 1'b1;
    applyStimulus(1'b1, 2'd1);
    stepCycles(1);
    checkOutput("midrst_led", 32'(led8), 32'h00);
    checkOutput("midrst_tick", 32'(tick8), 32'h0);
    rst = 1'b0;
    #1;
    stepCycles(2);
    checkOutput("postrst_tick_c2", 32'(tick8), 32'h0);
    stepCycles(1);
    checkOutput("postrst_tick_c3", 32'(tick8), 32'h1);
    checkOutput("postrst_led", 32'(led8), 32'h00);
    stepCycles(1);
    checkOutput("down_load", 32'(led8), 32'hFF);
    stepCycles(4);
    checkOutput("down_step", 32'(led8), 32'hFE);
    stepCycles(1016);
    checkOutput("down_zero", 32'(led8), 32'h00);
    stepCycles(4);
    checkOutput("down_wrap", 32'(led8), 32'hFF);

    // BOUNCE at width 3; first tick is a load of 0
    doReset(2'd2);
    for (int k = 0; k < 17; k++) begin
      stepCycles(3);
      checkOutput($sformatf("bounce_tick_%0d", k), 32'(tick3), 32'h1);
      stepCycles(1);
      checkOutput($sformatf("bounce_led_%0d", k), 32'(led3), 32'(bounceSeq[k]));
    end

    // WALK at width 4
    doReset(2'd3);
    for (int k = 0; k < 8; k++) begin
      stepCycles(4);
      checkOutput($sformatf("walk_led_%0d", k), 32'(led4), 32'(walkSeq[k]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
